// File: rtl/mux_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mux_pkg
// Description : Shared mode encodings and default sizing for the stream mux.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED    = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    localparam int   DEFAULT_NCH   = 4;
    localparam int   DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rr_arbiter
// Description : One-hot round-robin grant, searching upward from ptr+1 with wrap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NCH = DEFAULT_NCH,
    parameter int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    output logic [NCH-1:0] grant
);

    // One spare bit so ptr+k cannot overflow before the modulo fold.
    logic [SW:0] w_idx;
    logic        w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx = {1'b0, ptr} + (SW+1)'(k);
            if (w_idx >= (SW+1)'(NCH)) begin
                w_idx = w_idx - (SW+1)'(NCH);
            end
            if (!w_found && req[w_idx[SW-1:0]]) begin
                grant[w_idx[SW-1:0]] = 1'b1;
                w_found              = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : stream_mux_rr
// Description : N-channel valid/ready stream mux, fixed or round-robin select,
//               with a single registered output stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int NCH   = DEFAULT_NCH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_ch,
    input  logic                 out_ready
);

    logic [NCH-1:0]   w_rr_grant;
    logic [NCH-1:0]   w_fix_grant;
    logic [NCH-1:0]   w_grant;
    logic             w_load;
    logic             w_any;
    logic [WIDTH-1:0] w_data;
    logic [SW-1:0]    w_idx;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_ch;
    logic [SW-1:0]    r_ptr;

    rr_arbiter #(
        .NCH (NCH),
        .SW  (SW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (r_ptr),
        .grant (w_rr_grant)
    );

    // A sel value with no matching channel simply never produces a grant.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < NCH; i++) begin
            w_fix_grant[i] = in_valid[i] && (sel == SW'(i));
        end
    end

    assign w_grant  = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;
    assign w_load   = ~r_valid | out_ready;
    assign in_ready = w_grant & {NCH{w_load & rst_n}};
    assign w_any    = |w_grant;

    always_comb begin
        w_data = '0;
        w_idx  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[i]) begin
                w_data = w_data | in_data[i*WIDTH +: WIDTH];
                w_idx  = w_idx | SW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= SW'(NCH - 1);
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= w_data;
                r_ch   <= w_idx;
                if (mode == MODE_RR) begin
                    r_ptr <= w_idx;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_stream_mux_rr
// Description : Self-checking bench for stream_mux_rr with a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_stream_mux_rr;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;
    localparam int SW    = $clog2(NCH);

    typedef struct packed {
        logic           md;
        logic [SW-1:0]  s;
        logic [NCH-1:0] v;
        logic           r;
    } row_t;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 mode      = 1'b1;
    logic [SW-1:0]        sel       = '0;
    logic [NCH-1:0]       in_valid  = 4'b1111;
    logic [NCH*WIDTH-1:0] in_data   = {8'h13, 8'hA5, 8'h11, 8'h10};
    logic                 out_ready = 1'b1;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SW-1:0]        out_ch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(
        .NCH   (NCH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the output register as a one-slot buffer plus a priority pointer.
    bit               m_ok = 1'b0;
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_ch;
    int               m_ptr;

    function automatic int pick(bit md, int s, logic [NCH-1:0] v, int p);
        int c;
        if (!md) begin
            if (s < NCH) begin
                if (v[s]) return s;
            end
            return -1;
        end
        for (int k = 1; k <= NCH; k++) begin
            c = (p + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] exp_ready();
        int             g;
        logic [NCH-1:0] r;
        r = '0;
        g = pick(mode, int'(sel), in_valid, m_ptr);
        if (rst_n && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = NCH - 1;
            m_ok    = 1'b1;
        end else if (!m_valid || out_ready) begin
            g = pick(mode, int'(sel), in_valid, m_ptr);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*WIDTH +: WIDTH];
                m_ch    = g;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_in_ready", 64'(in_ready), 64'(exp_ready()));
            chk("m_out_valid", 64'(out_valid), 64'(m_valid));
            chk("m_out_data", 64'(out_data), 64'(m_data));
            chk("m_out_ch", 64'(out_ch), 64'(m_ch));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int         rr_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [7:0] rr_dat [8] = '{8'h10, 8'h11, 8'hA5, 8'h13, 8'h10, 8'h11, 8'hA5, 8'h13};
    int         alt_seq[4] = '{1, 3, 1, 3};
    row_t       rows[12] = '{
        '{1'b1, 2'd0, 4'b0110, 1'b1}, '{1'b1, 2'd0, 4'b0110, 1'b0},
        '{1'b1, 2'd0, 4'b0110, 1'b1}, '{1'b1, 2'd0, 4'b1001, 1'b1},
        '{1'b0, 2'd1, 4'b0010, 1'b1}, '{1'b0, 2'd1, 4'b0001, 1'b1},
        '{1'b0, 2'd0, 4'b0001, 1'b0}, '{1'b0, 2'd0, 4'b0001, 1'b1},
        '{1'b1, 2'd3, 4'b1111, 1'b1}, '{1'b1, 2'd3, 4'b0100, 1'b1},
        '{1'b1, 2'd0, 4'b0000, 1'b1}, '{1'b1, 2'd0, 4'b1000, 0}
    };

    initial begin
        // Reset held with all channels requesting: nothing may be accepted.
        tick();
        settle();
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_ch", 64'(out_ch), 64'h0);
        #1 rst_n = 1'b1;
        #1 chk("first_grant_ch0", 64'(in_ready), 64'b0001);

        // Round-robin rotation over four busy channels.
        tick();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("rr_valid", 64'(out_valid), 64'h1);
            chk("rr_ch", 64'(out_ch), 64'(rr_seq[i]));
            chk("rr_data", 64'(out_data), 64'(rr_dat[i]));
            tick();
        end

        // Fixed select of channel 2.
        mode = 1'b0;
        sel  = 2'd2;
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("fix_in_ready", 64'(in_ready), 64'b0100);
            chk("fix_data", 64'(out_data), 64'hA5);
            chk("fix_ch", 64'(out_ch), 64'h2);
            tick();
        end

        // Backpressure for three cycles, then release.
        do_reset();
        mode = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_valid", 64'(out_valid), 64'h1);
            chk("bp_ch", 64'(out_ch), 64'h0);
            chk("bp_data", 64'(out_data), 64'h10);
            chk("bp_in_ready", 64'(in_ready), 64'h0);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(in_ready), 64'b0010);
        tick();
        settle();
        chk("bp_next_ch", 64'(out_ch), 64'h1);

        // Alternating channels 1 and 3, then idle.
        do_reset();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("alt_ch", 64'(out_ch), 64'(alt_seq[i]));
        end
        #1 in_valid = '0;
        tick();
        settle();
        chk("idle_valid", 64'(out_valid), 64'h0);
        chk("idle_ch_held", 64'(out_ch), 64'h3);
        #1 in_valid = 4'b1111;
        #1 chk("idle_ptr_held", 64'(in_ready), 64'b0001);

        // Reset in the middle of a stream.
        do_reset();
        tick();
        tick();
        settle();
        chk("mid_valid_before", 64'(out_valid), 64'h1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_in_ready", 64'(in_ready), 64'h0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("mid_out_valid", 64'(out_valid), 64'h0);
        chk("mid_out_data", 64'(out_data), 64'h0);
        chk("mid_grant_ch0", 64'(in_ready), 64'b0001);

        // Fixed select of an idle channel, then same-cycle switch to round-robin.
        do_reset();
        mode     = 1'b0;
        sel      = 2'd3;
        in_valid = 4'b0111;
        settle();
        chk("sel_idle_ready", 64'(in_ready), 64'h0);
        tick();
        settle();
        chk("sel_idle_valid", 64'(out_valid), 64'h0);
        #1 mode = 1'b1;
        #1 chk("switch_ready", 64'(in_ready), 64'b0001);
        tick();
        settle();
        chk("switch_ch", 64'(out_ch), 64'h0);
        chk("switch_valid", 64'(out_valid), 64'h1);

        // Mixed directed patterns, checked cycle by cycle against the model.
        #1;
        for (int i = 0; i < 12; i++) begin
            mode      = rows[i].md;
            sel       = rows[i].s;
            in_valid  = rows[i].v;
            out_ready = rows[i].r;
            tick();
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
